// File: rtl/mat_stream_packer.sv
// mat_stream_packer
//   Collects DATA_WIDTH-bit matrix elements, one per handshake, in row-major
//   order and presents them as one flat packed matrix (element 0 at the LSBs)
//   with a mat_valid/mat_ready handshake. The matrix is held frozen until the
//   consumer takes it.
//   Optional build macro MATPACK_LAST_CHECK_EN adds in_last framing checks
//   and a sticky err output.
module mat_stream_packer #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int MATRIX_SIZE = 121,
  localparam int CNT_W       = $clog2(MATRIX_SIZE + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] mat,
  output logic                            mat_valid,
  input  logic                            mat_ready,
  output logic [CNT_W-1:0]                fill_count
`ifdef MATPACK_LAST_CHECK_EN
  ,
  input  logic                            in_last,
  output logic                            err
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MATRIX_SIZE - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                            r_state;
  state_t                            w_state_next;
  logic [CNT_W-1:0]                  r_fill_count;
  logic [CNT_W-1:0]                  w_count_next;
  logic [MATRIX_SIZE*DATA_WIDTH-1:0] r_mat;
  logic                              w_store;
  logic                              w_is_last;
  logic [MATRIX_SIZE-1:0]            w_elem_we;
  logic                              r_err;
  logic                              w_err_next;

  assign w_is_last = (r_fill_count == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, element-store and counter decisions; flush overrides all
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_fill_count;
    w_store      = 1'b0;
    w_err_next   = r_err;
    if (flush) begin
      w_state_next = S_FILL;
      w_count_next = '0;
      w_err_next   = 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
`ifdef MATPACK_LAST_CHECK_EN
            if (in_last != w_is_last) begin
              // Bad framing: drop the partial matrix and the offending element
              w_err_next   = 1'b1;
              w_count_next = '0;
            end else begin
              w_store = 1'b1;
            end
`else
            w_store = 1'b1;
`endif
            if (w_store) begin
              if (w_is_last) begin
                w_state_next = S_FULL;
                w_count_next = '0;
              end else begin
                w_count_next = r_fill_count + CNT_W'(1);
              end
            end
          end
        end
        S_FULL: begin
          if (mat_ready) begin
            w_state_next = S_FILL;
          end
        end
        default: begin
          w_state_next = S_FILL;
          w_count_next = '0;
        end
      endcase
    end
  end

  // Element counter and sticky framing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_fill_count <= w_count_next;
      r_err        <= w_err_next;
    end
  end

  // Per-element write enables decoded from the fill position
  generate
    for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_we
      assign w_elem_we[gi] = w_store && (r_fill_count == CNT_W'(gi));
    end
  endgenerate

  // Matrix storage; never cleared between matrices, mat_valid qualifies it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat <= '0;
    end else begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        if (w_elem_we[i]) begin
          r_mat[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        end
      end
    end
  end

  // Handshake outputs come straight from state, no path from in_*
  assign in_ready   = (r_state == S_FILL);
  assign mat_valid  = (r_state == S_FULL);
  assign mat        = r_mat;
  assign fill_count = r_fill_count;
`ifdef MATPACK_LAST_CHECK_EN
  assign err        = r_err;
`else
  logic w_unused;
  assign w_unused = r_err;
`endif

endmodule

// File: tb/tb_mat_stream_packer.sv
// Randomized bench for mat_stream_packer against a queue-based reference model.
module tb_mat_stream_packer;

  localparam int DW = 8;
  localparam int MS = 121;
  localparam int CW = $clog2(MS + 1);
  localparam int MW = MS * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mat;
  logic          mat_valid;
  logic          mat_ready = 1'b0;
  logic [CW-1:0] fill_count;
`ifdef MATPACK_LAST_CHECK_EN
  logic          in_last = 1'b0;
  logic          err;
`endif

  mat_stream_packer #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mat        (mat),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .fill_count (fill_count)
`ifdef MATPACK_LAST_CHECK_EN
    ,
    .in_last    (in_last),
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: matrix either full (waiting for consumer) or being
  // filled from the list of accepted elements; stored bytes persist.
  bit          m_full = 1'b0;
  byte unsigned m_q[$];
  logic [7:0]  m_mat[MS];
  bit          m_err = 1'b0;

  task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_q.delete();
    m_err = 1'b0;
    for (int i = 0; i < MS; i++) m_mat[i] = 8'h00;
  endtask

  task automatic model_step(input bit v, input byte unsigned d, input bit mr, input bit fl, input bit lst);
    bit ok;
    if (fl) begin
      m_full = 1'b0;
      m_q.delete();
      m_err = 1'b0;
    end else if (m_full) begin
      if (mr) m_full = 1'b0;
    end else if (v) begin
      ok = 1'b1;
`ifdef MATPACK_LAST_CHECK_EN
      if (lst != (m_q.size() == MS - 1)) begin
        m_err = 1'b1;
        m_q.delete();
        ok = 1'b0;
      end
`else
      ok = ok | lst | ~lst;
`endif
      if (ok) begin
        m_mat[m_q.size()] = d;
        m_q.push_back(d);
        if (m_q.size() == MS) begin
          m_full = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  function automatic logic [MW-1:0] model_mat();
    logic [MW-1:0] v;
    for (int i = 0; i < MS; i++) v[i*DW +: DW] = m_mat[i];
    return v;
  endfunction

  task automatic expect_all(input string where);
    chk({where, ".in_ready"}, MW'(in_ready), MW'(!m_full));
    chk({where, ".mat_valid"}, MW'(mat_valid), MW'(m_full));
    chk({where, ".fill_count"}, MW'(fill_count), MW'(m_q.size()));
    chk({where, ".mat"}, mat, model_mat());
`ifdef MATPACK_LAST_CHECK_EN
    chk({where, ".err"}, MW'(err), MW'(m_err));
`endif
  endtask

  // One clock of stimulus; inputs change 1 time unit after the rising edge
  task automatic step(input bit v, input byte unsigned d, input bit mr, input bit fl, input bit lst, input string where);
    in_valid  = v;
    in_data   = d;
    mat_ready = mr;
    flush     = fl;
`ifdef MATPACK_LAST_CHECK_EN
    in_last   = lst;
`endif
    @(posedge clk);
    model_step(v, d, mr, fl, lst);
    #1;
    expect_all(where);
  endtask

  function automatic bit nat_last();
    return (m_q.size() == MS - 1);
  endfunction

  task automatic fill(input int n, input string where);
    for (int i = 0; i < n; i++) step(1'b1, byte'($urandom_range(0, 255)), 1'b0, 1'b0, nat_last(), where);
  endtask

  task automatic async_reset(input string where);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    expect_all(where);
    #2;
    rst_n = 1'b1;
  endtask

  logic [MW-1:0] snap;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential 0x01..0x79 with consumer always ready
    for (int i = 0; i < MS; i++) step(1'b1, byte'(i + 1), 1'b1, 1'b0, (i == MS - 1), "seq");
    chk("seq.byte0", MW'(mat[7:0]), MW'(8'h01));
    chk("seq.byte120", MW'(mat[967:960]), MW'(8'h79));
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "seq.take");

    // Hold full matrix with consumer stalled while producer pushes
    fill(MS, "hold.fill");
    snap = mat;
    for (int i = 0; i < 20; i++) step(1'b1, byte'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, "hold");
    chk("hold.stable", mat, snap);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, "hold.release");

    // Flush mid-fill with a same-cycle element, then a clean matrix
    fill(50, "flush.pre");
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, "flush");
    fill(MS, "flush.post");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "flush.take");

    // Flush while full voids a same-cycle transfer
    fill(MS, "flushfull.fill");
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "flushfull");

    // Asynchronous reset mid-fill and while full
    fill(70, "arst.fill");
    async_reset("arst.fill");
    fill(MS, "arst.full.fill");
    async_reset("arst.full");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "arst.after");

`ifdef MATPACK_LAST_CHECK_EN
    // Early last on element 60 raises err; flush clears it
    fill(60, "last.pre");
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, "last.early");
    step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, "last.resume");
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "last.flush");
    // Missing last on the final element
    fill(MS - 1, "last.miss.pre");
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, "last.miss");
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "last.miss.flush");
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit v, mr, fl, lst;
      v   = ($urandom_range(0, 3) != 0);
      mr  = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 199) == 0);
      lst = nat_last();
`ifdef MATPACK_LAST_CHECK_EN
      if ($urandom_range(0, 299) == 0) lst = ~lst;
`endif
      step(v, byte'($urandom_range(0, 255)), mr, fl, lst, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
